// File: rtl/sp_ram_pkg.sv
// sp_ram_pkg: shared state encoding and default sizes for the single-port RAM front-end
package sp_ram_pkg;
  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_e;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
endpackage

// File: rtl/sp_ram_req_ctrl_rsp_hold_reg.sv
// rsp_hold_reg: one-entry read response stage that parks RAM data while the consumer stalls
module rsp_hold_reg
  import sp_ram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             rsp_ready,
  input  logic [WIDTH-1:0] ram_dout,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata
);
  logic valid_q, valid_d, held_q, held_d, stall;
  logic [WIDTH-1:0] hold_q, hold_d;
  always_comb begin
    stall = valid_q & ~rsp_ready;
    valid_d = load | stall;
    held_d = stall;
    rsp_rdata = held_q ? hold_q : ram_dout;
    hold_d = stall ? rsp_rdata : hold_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      held_q <= 1'b0;
      hold_q <= '0;
    end else begin
      valid_q <= valid_d;
      held_q <= held_d;
      hold_q <= hold_d;
    end
  end
  assign rsp_valid = valid_q;
endmodule

// File: rtl/sp_ram_req_ctrl.sv
// sp_ram_req_ctrl: request/response front-end for a single-port sync-read RAM with sweep clear
module sp_ram_req_ctrl
  import sp_ram_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int AW            = $clog2(DEPTH),
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  input  logic             clr_req,
  output logic             init_busy,
  output logic             ram_wr,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout
);
  state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic clr_pend_q, clr_pend_d;
  logic init, acc, rd_acc, rsp_hs, pending;
  rsp_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk(clk),
    .rst(rst),
    .load(rd_acc),
    .rsp_ready(rsp_ready),
    .ram_dout(ram_dout),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata)
  );
  always_comb begin
    init = (state_q == ST_INIT) & ~rst;
    req_ready = (state_q == ST_RUN) & ~clr_pend_q & ~rst & ~(rsp_valid & ~rsp_ready);
    acc = req_valid & req_ready;
    rd_acc = acc & ~req_wr;
    rsp_hs = rsp_valid & rsp_ready;
    pending = (rsp_valid & ~rsp_ready) | rd_acc;
    ram_wr = init | (acc & req_wr);
    ram_addr = init ? cnt_q : req_addr;
    ram_din = init ? '0 : req_wdata;
    init_busy = state_q != ST_RUN;
    cnt_d = init ? cnt_q + 1'b1 : cnt_q;
    state_d = state_q;
    clr_pend_d = clr_pend_q;
    if (state_q == ST_INIT) begin
      clr_pend_d = 1'b0;
      state_d = (cnt_q == AW'(DEPTH - 1)) ? ST_RUN : ST_INIT;
    end else if (state_q == ST_RUN && clr_req) begin
      clr_pend_d = 1'b1;
      state_d = pending ? ST_DRAIN : ST_INIT;
    end else if (state_q == ST_DRAIN && rsp_hs) begin
      clr_pend_d = 1'b0;
      state_d = ST_INIT;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT_ON_RESET ? ST_INIT : ST_RUN;
      cnt_q <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      clr_pend_q <= clr_pend_d;
    end
  end
endmodule

// File: tb/tb_sp_ram_req_ctrl.sv
// tb_sp_ram_req_ctrl: directed stimulus with a response scoreboard for sp_ram_req_ctrl
module tb_sp_ram_req_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_wr, rsp_valid, rsp_ready, clr_req, init_busy, ram_wr;
  logic [2:0] req_addr, ram_addr;
  logic [7:0] req_wdata, rsp_rdata, ram_din, ram_dout;
  logic r1_valid, r1_ready, r1_wr, r1_rsp_valid, r1_busy, r1_ram_wr;
  logic [2:0] r1_addr, r1_ram_addr;
  logic [7:0] r1_wdata, r1_rdata, r1_ram_din;
  logic r1_rsp_ready = 1'b1;
  logic r1_clr = 1'b0;
  logic [7:0] r1_dout = 8'h00;
  logic [7:0] mem [0:7];
  logic [7:0] model [0:7];
  logic [7:0] exp_q [$];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  sp_ram_req_ctrl #(.WIDTH(8), .DEPTH(8), .INIT_ON_RESET(1'b1)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .clr_req(clr_req), .init_busy(init_busy), .ram_wr(ram_wr),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );
  sp_ram_req_ctrl #(.WIDTH(8), .DEPTH(8), .INIT_ON_RESET(1'b0)) u1 (
    .clk(clk), .rst(rst), .req_valid(r1_valid), .req_ready(r1_ready), .req_wr(r1_wr),
    .req_addr(r1_addr), .req_wdata(r1_wdata), .rsp_valid(r1_rsp_valid), .rsp_ready(r1_rsp_ready),
    .rsp_rdata(r1_rdata), .clr_req(r1_clr), .init_busy(r1_busy), .ram_wr(r1_ram_wr),
    .ram_addr(r1_ram_addr), .ram_din(r1_ram_din), .ram_dout(r1_dout)
  );
  initial for (int i = 0; i < 8; i++) mem[i] = 8'hEE;
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_rdata), 32'hFFFF_FFFF);
      else if (rsp_ready) chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
      else begin
        chk("stall_rdata", 32'(rsp_rdata), 32'(exp_q[0]));
        chk("stall_req_ready", 32'(req_ready), 32'd0);
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    req_valid = 1'b0;
    req_wr = 1'b0;
  endtask
  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
  endtask
  task automatic issue(input logic wr, input logic [2:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_wr = wr;
    req_addr = a;
    req_wdata = d;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    chk("req_accept", 32'(req_ready), 32'd1);
    if (req_ready && wr) begin
      chk("wr_ram_wr", 32'(ram_wr), 32'd1);
      chk("wr_ram_addr", 32'(ram_addr), 32'(a));
      chk("wr_ram_din", 32'(ram_din), 32'(d));
      model[a] = d;
    end
    if (req_ready && !wr) exp_q.push_back(model[a]);
    cyc();
  endtask
  task automatic sweep_check();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("sweep_busy", 32'(init_busy), 32'd1);
      chk("sweep_ram_wr", 32'(ram_wr), 32'd1);
      chk("sweep_addr", 32'(ram_addr), 32'(i));
      chk("sweep_din", 32'(ram_din), 32'd0);
      chk("sweep_req_ready", 32'(req_ready), 32'd0);
      chk("u1_ram_wr_idle", 32'(r1_ram_wr), 32'd0);
      chk("u1_req_ready", 32'(r1_ready), 32'd1);
      chk("u1_busy", 32'(r1_busy), 32'd0);
      chk("u1_rsp_valid", 32'(r1_rsp_valid), 32'd0);
    end
    @(negedge clk);
    chk("post_sweep_busy", 32'(init_busy), 32'd0);
    chk("post_sweep_ready", 32'(req_ready), 32'd1);
    clear_model();
    cyc();
  endtask
  initial begin
    rst = 1'b1;
    idle();
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    clr_req = 1'b0;
    r1_valid = 1'b0;
    r1_wr = 1'b0;
    r1_addr = '0;
    r1_wdata = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_u1_busy", 32'(r1_busy), 32'd0);
    chk("rst_u1_ready", 32'(r1_ready), 32'd0);
    rst = 1'b0;
    sweep_check();
    r1_valid = 1'b1;
    r1_wr = 1'b1;
    r1_addr = 3'd2;
    r1_wdata = 8'h5A;
    @(negedge clk);
    chk("u1_wr", 32'(r1_ram_wr), 32'd1);
    chk("u1_addr", 32'(r1_ram_addr), 32'd2);
    chk("u1_din", 32'(r1_ram_din), 32'h5A);
    cyc();
    r1_valid = 1'b0;
    @(negedge clk);
    chk("u1_wr_after", 32'(r1_ram_wr), 32'd0);
    chk("u1_rdata", 32'(r1_rdata), 32'd0);
    cyc();
    issue(1'b1, 3'd3, 8'hA5);
    issue(1'b0, 3'd3, 8'h00);
    idle();
    @(negedge clk);
    chk("rd_latency_valid", 32'(rsp_valid), 32'd1);
    cyc();
    @(negedge clk);
    chk("rd_valid_clears", 32'(rsp_valid), 32'd0);
    cyc();
    for (int i = 0; i < 8; i++) issue(1'b1, 3'(i), 8'h30 + 8'(i));
    issue(1'b0, 3'd0, 8'h00);
    rsp_ready = 1'b0;
    fork
      for (int i = 1; i < 8; i++) issue(1'b0, 3'(i), 8'h00);
      begin
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    idle();
    repeat (4) cyc();
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    rsp_ready = 1'b0;
    issue(1'b0, 3'd5, 8'h00);
    clr_req = 1'b1;
    @(negedge clk);
    chk("clr_still_run", 32'(init_busy), 32'd0);
    cyc();
    clr_req = 1'b0;
    req_wr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("drain_busy", 32'(init_busy), 32'd1);
      chk("drain_ready", 32'(req_ready), 32'd0);
      chk("drain_ram_wr", 32'(ram_wr), 32'd0);
      cyc();
    end
    idle();
    rsp_ready = 1'b1;
    cyc();
    sweep_check();
    issue(1'b0, 3'd3, 8'h00);
    idle();
    repeat (3) cyc();
    issue(1'b1, 3'd6, 8'h77);
    issue(1'b0, 3'd0, 8'h00);
    issue(1'b0, 3'd6, 8'h00);
    issue(1'b0, 3'd1, 8'h00);
    rst = 1'b1;
    exp_q.delete();
    idle();
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(init_busy), 32'd1);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    cyc();
    rst = 1'b0;
    sweep_check();
    issue(1'b0, 3'd6, 8'h00);
    idle();
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
